dram_cmd_sched: RTL

In-order DDR4 command scheduler between the memory-controller request queue and the DIMM command bus. It accepts one request at a time and decodes bank group, bank, row and column. A 16-entry open-row table drives each request through hit, closed or miss sequences (PRE/ACT/RD/WR), with tRP, tRCD and per-bank tRAS enforced in DIMM clock cycles. It pulses a completion when the data burst finishes.

---
 rtl/dram_cmd_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_sched.sv
// In-order DDR4 command scheduler: one request at a time, open-row table,
// PRE/ACT/RD/WR sequencing with tRP, tRCD and per-bank tRAS enforcement.
module dram_cmd_sched #(
  parameter int unsigned T_RCD   = 24,
  parameter int unsigned T_RP    = 24,
  parameter int unsigned T_RAS   = 52,
  parameter int unsigned T_CL    = 24,
  parameter int unsigned T_CWL   = 20,
  parameter int unsigned T_BURST = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [32:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic [1:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [14:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        done_valid,
  output logic [1:0]  done_op,
  output logic [32:0] done_addr
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRE       = 3'd1;
  localparam logic [2:0] S_WAIT_RP   = 3'd2;
  localparam logic [2:0] S_ACT       = 3'd3;
  localparam logic [2:0] S_WAIT_RCD  = 3'd4;
  localparam logic [2:0] S_CAS       = 3'd5;
  localparam logic [2:0] S_WAIT_DATA = 3'd6;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD);
  localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS);
  localparam logic [CNT_W-1:0] RD_LAT = CNT_W'(T_CL + T_BURST);
  localparam logic [CNT_W-1:0] WR_LAT = CNT_W'(T_CWL + T_BURST);

  logic [2:0]       state, next_state;
  logic [1:0]       op_q;
  logic [32:0]      addr_q;
  logic [CNT_W-1:0] tmr;

  logic             bank_open [16];
  logic [14:0]      bank_row  [16];
  logic [CNT_W-1:0] bank_ras  [16];

  logic [32:0]      sel_addr;
  logic [1:0]       sel_op;
  logic [3:0]       sel_bank;
  logic [14:0]      sel_row;
  logic [9:0]       sel_col;
  logic             issue_pre, issue_act, issue_cas;

  assign req_ready = (state == S_IDLE);

  // Commands are registered, so decisions for the next cycle use the incoming
  // request while idle and the latched request otherwise.
  always_comb begin
    sel_addr = (state == S_IDLE) ? req_addr : addr_q;
    sel_op   = (state == S_IDLE) ? req_op   : op_q;
    sel_bank = {sel_addr[7:6], sel_addr[9:8]};
    sel_row  = sel_addr[32:18];
    sel_col  = {sel_addr[17:10], sel_addr[5:4]};
  end

  // Next-state decode; a cmd_valid seen in S_PRE means the PRE went out this cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (!bank_open[sel_bank])               next_state = S_ACT;
          else if (bank_row[sel_bank] == sel_row) next_state = S_CAS;
          else                                    next_state = S_PRE;
        end
      end
      S_PRE:       next_state = cmd_valid ? ((tmr <= ONE) ? S_ACT : S_WAIT_RP) : S_PRE;
      S_WAIT_RP:   next_state = (tmr <= ONE) ? S_ACT : S_WAIT_RP;
      S_ACT,
      S_WAIT_RCD:  next_state = (tmr <= ONE) ? S_CAS : S_WAIT_RCD;
      S_CAS,
      S_WAIT_DATA: next_state = done_valid ? S_IDLE : S_WAIT_DATA;
      default:     next_state = S_IDLE;
    endcase
  end

  // Issue strobes for the command that appears on the bus next cycle.
  always_comb begin
    issue_pre = (next_state == S_PRE) && (bank_ras[sel_bank] <= ONE);
    issue_act = (next_state == S_ACT);
    issue_cas = (next_state == S_CAS);
  end

  // FSM, request latch, shared spacing timer and registered command/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      tmr        <= '0;
      cmd_valid  <= 1'b0;
      cmd_type   <= CMD_NOP;
      cmd_bg     <= '0;
      cmd_ba     <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      done_valid <= 1'b0;
      done_op    <= '0;
      done_addr  <= '0;
    end else begin
      state <= next_state;
      if (req_valid && req_ready) begin
        op_q   <= req_op;
        addr_q <= req_addr;
      end

      if (issue_pre)      tmr <= RP_LD;
      else if (issue_act) tmr <= RCD_LD;
      else if (issue_cas) tmr <= (sel_op == 2'd1) ? WR_LAT : RD_LAT;
      else if (tmr != '0) tmr <= tmr - ONE;

      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      if (issue_pre || issue_act || issue_cas) begin
        cmd_valid <= 1'b1;
        cmd_bg    <= sel_addr[7:6];
        cmd_ba    <= sel_addr[9:8];
      end
      if (issue_pre) cmd_type <= CMD_PRE;
      if (issue_act) begin
        cmd_type <= CMD_ACT;
        cmd_row  <= sel_row;
      end
      if (issue_cas) begin
        cmd_type <= (sel_op == 2'd1) ? CMD_WR : CMD_RD;
        cmd_col  <= sel_col;
      end

      done_valid <= ((state == S_CAS) || (state == S_WAIT_DATA)) && (tmr == ONE);
      if (((state == S_CAS) || (state == S_WAIT_DATA)) && (tmr == ONE)) begin
        done_op   <= op_q;
        done_addr <= addr_q;
      end
    end
  end

  // Open-row table; tRAS counters run down every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) begin
        bank_open[i] <= 1'b0;
        bank_row[i]  <= '0;
        bank_ras[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (issue_act && (sel_bank == 4'(i))) begin
          bank_open[i] <= 1'b1;
          bank_row[i]  <= sel_row;
          bank_ras[i]  <= RAS_LD;
        end else begin
          if (issue_pre && (sel_bank == 4'(i))) bank_open[i] <= 1'b0;
          if (bank_ras[i] != '0) bank_ras[i] <= bank_ras[i] - ONE;
        end
      end
    end
  end

endmodule
